digit_lock_ctrl: RTL and testbench
==================================

// Module: digit_lock_ctrl
//
// PURPOSE
//   Lock controller downstream of the per-digit mod-10 button counters. Samples the
//   BCD digit values on an "enter" press, compares them with the stored code, and drives
//   unlock and alarm outputs.
//   Counts failed attempts, enforces a timed lockout, and re-locks automatically.
//   Raw push-button inputs are synchronised and edge-detected inside this block.
//
// PARAMETERS
//   NUM_DIGITS     4         number of BCD digits compared
//   DEFAULT_CODE   16'h1234  reset code, packed BCD, digit 0 in [3:0]; width 4*NUM_DIGITS
//   MAX_FAILS      3         consecutive mismatches that trigger LOCKOUT (>=1)
//   LOCKOUT_CYCLES 1000      clk cycles spent in LOCKOUT (>=1)
//   UNLOCK_CYCLES  500       clk cycles before auto re-lock; 0 = never auto re-lock
//
// PORTS
//   clk        in   1              system clock, rising edge
//   rst_n      in   1              asynchronous reset, active low
//   digits_i   in   4*NUM_DIGITS   packed BCD digits from the mod-10 counters, digit 0 in [3:0]
//   enter_btn  in   1              raw enter button, asynchronous, active high
//   lock_btn   in   1              raw lock button, asynchronous, active high
//   set_btn    in   1              raw set-code button; ignored unless the macro is defined
//   unlocked   out  1              registered; 1 only in UNLOCKED
//   alarm      out  1              registered; 1 only in LOCKOUT
//   fail_cnt   out  $clog2(MAX_FAILS+1)  registered consecutive-mismatch count
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=LOCKED, code=DEFAULT_CODE, fail_cnt=0, timer=0, unlocked=0, alarm=0.
//     Reset during any state, including LOCKOUT, clears all outputs immediately.
//   - Each button input passes through a 2-FF synchroniser and a rising-edge detector.
//     The result is a 1-cycle pulse. A level held high produces exactly one pulse.
//   - Latency: a button rise seen at edge N produces its state/output change at edge N+3.
//   - LOCKED: on an enter pulse, compare every digit of digits_i with code.
//       - A digit value >9 counts as a mismatch.
//       - Match -> UNLOCKED; fail_cnt=0; timer=UNLOCK_CYCLES.
//       - Mismatch -> fail_cnt+1. If the new value equals MAX_FAILS -> LOCKOUT with timer=LOCKOUT_CYCLES.
//       - lock pulse: no effect.
//   - UNLOCKED: enter pulse ignored. Timer decrements when nonzero (UNLOCK_CYCLES>0 only).
//       - Timer reaches 0, or lock pulse -> LOCKED.
//       - lock and set pulses in the same cycle: lock wins and code is unchanged.
//   - LOCKOUT: all button pulses discarded; timer decrements each cycle.
//       - On reaching 0 -> LOCKED with fail_cnt=0. alarm stays 1 for exactly LOCKOUT_CYCLES cycles.
//   - fail_cnt saturates at MAX_FAILS and never wraps.
//   - digits_i is sampled only in the cycle of the enter pulse and needs no other stability.
//
// CONFIGURATION
//   DIGIT_LOCK_CODE_CHANGE_EN
//     defined: a set pulse in UNLOCKED writes digits_i into code, then -> LOCKED next cycle.
//       - If any digit is >9 the write is rejected and the state stays UNLOCKED.
//       - The set pulse also reloads the auto re-lock timer.
//     undefined: set_btn is unused; code is the constant DEFAULT_CODE and no code register is built.
//
// STRUCTURE
//   - Package digit_lock_pkg: lock_state_t enum (LOCKED, UNLOCKED, LOCKOUT); DIGIT_W=4; BCD_MAX=9.
//   - Sub-module btn_edge_sync: 2-FF synchroniser plus rising-edge pulse. One instance per button.
//   - Top level: FSM, comparator, fail counter, down-timer, and code register.
//
// TESTING (short timers: UNLOCK_CYCLES=20, LOCKOUT_CYCLES=30)
//   1. Reset, digits_i=16'h1234, enter pulse -> unlocked=1 at edge+3; fail_cnt=0; alarm=0.
//   2. Three enters with 16'h1235 -> fail_cnt 1,2,3; alarm=1 after the third, for exactly 30 cycles;
//      then fail_cnt=0. An enter with 16'h1234 during LOCKOUT is ignored.
//   3. Unlock, no buttons -> unlocked drops after 20 cycles. Unlock, then lock pulse -> unlocked=0 at edge+3.
//   4. digits_i=16'h12A4, enter -> mismatch, fail_cnt=1. Enter held high 10 cycles -> one attempt only.
//   5. Macro on: unlock, digits_i=16'h9876, set pulse -> LOCKED. Enter 16'h1234 fails; enter 16'h9876 unlocks.
//      Macro off: the same sequence leaves the code at 16'h1234.
//   6. rst_n low mid-LOCKOUT -> alarm=0 and fail_cnt=0 immediately, without waiting for clk.
//      After release, 16'h1234 unlocks (code restored to DEFAULT_CODE).

Source files
------------

// File: rtl/digit_lock_pkg.sv
// -----------------------------------------------------------------------------
// digit_lock_pkg
//   Shared types and constants for the digit lock controller.
//   - lock_state_t : controller state encoding (LOCKED, UNLOCKED, LOCKOUT)
//   - DIGIT_W      : width of one BCD digit
//   - BCD_MAX      : largest legal BCD digit value
//   - digit_is_bcd : 1 when a 4-bit digit holds a legal BCD value (0..9)
// -----------------------------------------------------------------------------
package digit_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } lock_state_t;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  function automatic logic digit_is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/digit_lock_btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
//   Brings one raw, asynchronous push-button into the clk domain through a
//   2-FF synchroniser and turns each rising edge into a registered 1-cycle
//   pulse. A level held high yields exactly one pulse. A rise captured by the
//   first flop at edge N is visible on pulse after edge N+2, so the consumer
//   acts on it at edge N+3.
//
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous reset, active low (clears the whole chain)
//   btn    in  raw button level, asynchronous, active high
//   pulse  out 1-cycle pulse per rising edge of btn
// -----------------------------------------------------------------------------
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;
  logic vld_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      vld_p3  <= 1'b0;
    end else begin
      // p0/p1: metastability synchroniser
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // p2: previous synchronised level for edge detection
      prev_p2 <= sync_p1;
      // p3: registered rising-edge pulse
      vld_p3  <= sync_p1 & ~prev_p2;
    end
  end

  assign pulse = vld_p3;

endmodule

// File: rtl/digit_lock_ctrl.sv
// -----------------------------------------------------------------------------
// digit_lock_ctrl
//   Lock controller fed by per-digit mod-10 counters. On an enter press it
//   compares the packed BCD digits with the stored code; a match unlocks,
//   MAX_FAILS consecutive mismatches force a timed LOCKOUT (alarm). UNLOCKED
//   re-locks on a lock press or after UNLOCK_CYCLES cycles (0 = never).
//
//   Optional feature macro: DIGIT_LOCK_CODE_CHANGE_EN
//     defined   : a set press in UNLOCKED loads digits_i into a code register
//                 and returns to LOCKED; a code with any digit >9 is rejected
//                 (stays UNLOCKED). Any set press reloads the re-lock timer.
//     undefined : set_btn is unused and the code is the constant DEFAULT_CODE.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous reset, active low
//   digits_i  in   packed BCD digits, digit 0 in [3:0]
//   enter_btn in   raw enter button (async, active high)
//   lock_btn  in   raw lock button (async, active high)
//   set_btn   in   raw set-code button (used only with the macro defined)
//   unlocked  out  registered, 1 only in UNLOCKED
//   alarm     out  registered, 1 only in LOCKOUT
//   fail_cnt  out  registered consecutive-mismatch count
// -----------------------------------------------------------------------------
module digit_lock_ctrl
  import digit_lock_pkg::*;
#(
  parameter int                          NUM_DIGITS     = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = 16'h1234,
  parameter int                          MAX_FAILS      = 3,
  parameter int                          LOCKOUT_CYCLES = 1000,
  parameter int                          UNLOCK_CYCLES  = 500
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0]     digits_i,
  input  logic                              enter_btn,
  input  logic                              lock_btn,
  input  logic                              set_btn,
  output logic                              unlocked,
  output logic                              alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt
);

  localparam int CODE_W    = DIGIT_W * NUM_DIGITS;
  localparam int FAIL_W    = $clog2(MAX_FAILS + 1);
  localparam int TIMER_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_FAILS);

  // Every digit must be legal BCD; a value >9 can never match.
  function automatic logic code_is_bcd(input logic [CODE_W-1:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ok &= digit_is_bcd(c[i*DIGIT_W +: DIGIT_W]);
    end
    return ok;
  endfunction

  lock_state_t          state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [FAIL_W-1:0]    fail_d;
  logic                 unlocked_d, alarm_d;
  logic                 enter_pulse, lock_pulse;
  logic [CODE_W-1:0]    code;
  logic                 code_match;

  btn_edge_sync u_enter_sync (.clk(clk), .rst_n(rst_n), .btn(enter_btn), .pulse(enter_pulse));
  btn_edge_sync u_lock_sync  (.clk(clk), .rst_n(rst_n), .btn(lock_btn),  .pulse(lock_pulse));

`ifdef DIGIT_LOCK_CODE_CHANGE_EN
  logic              set_pulse;
  logic              code_we;
  logic [CODE_W-1:0] code_q;

  btn_edge_sync u_set_sync (.clk(clk), .rst_n(rst_n), .btn(set_btn), .pulse(set_pulse));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= DEFAULT_CODE;
    end else if (code_we) begin
      code_q <= digits_i;
    end
  end

  assign code = code_q;
`else
  logic unused_set_btn;
  assign unused_set_btn = set_btn;
  assign code           = DEFAULT_CODE;
`endif

  assign code_match = code_is_bcd(digits_i) && (digits_i == code);

  // State register; outputs are registered from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOCKED;
      timer_q  <= '0;
      fail_cnt <= '0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_cnt <= fail_d;
      unlocked <= unlocked_d;
      alarm    <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_cnt;
`ifdef DIGIT_LOCK_CODE_CHANGE_EN
    code_we = 1'b0;
`endif
    unique case (state_q)
      LOCKED: begin
        if (enter_pulse) begin
          if (code_match) begin
            state_d = UNLOCKED;
            fail_d  = '0;
            timer_d = UNLOCK_LOAD;
          end else begin
            // LOCKOUT is entered exactly when the count reaches the limit,
            // so the counter can never pass MAX_FAILS.
            fail_d = fail_cnt + FAIL_W'(1);
            if (fail_d == FAIL_LIMIT) begin
              state_d = LOCKOUT;
              timer_d = LOCKOUT_LOAD;
            end
          end
        end
      end
      UNLOCKED: begin
        if (lock_pulse) begin
          state_d = LOCKED;
          timer_d = '0;
`ifdef DIGIT_LOCK_CODE_CHANGE_EN
        end else if (set_pulse) begin
          timer_d = UNLOCK_LOAD;
          if (code_is_bcd(digits_i)) begin
            code_we = 1'b1;
            state_d = LOCKED;
          end
`endif
        end else if ((UNLOCK_CYCLES != 0) && (timer_q != '0)) begin
          timer_d = timer_q - TIMER_ONE;
          if (timer_q == TIMER_ONE) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKOUT: begin
        if (timer_q <= TIMER_ONE) begin
          state_d = LOCKED;
          timer_d = '0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d = LOCKED;
        timer_d = '0;
        fail_d  = '0;
      end
    endcase
  end

  always_comb begin
    unlocked_d = (state_d == UNLOCKED);
    alarm_d    = (state_d == LOCKOUT);
  end

endmodule

// File: tb/tb_digit_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_lock_ctrl
//   Randomised and directed stimulus for digit_lock_ctrl with short timers.
//   A reference model, clocked alongside the DUT, predicts {unlocked, alarm,
//   fail_cnt} for every edge and queues the prediction; an independent
//   monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_digit_lock_ctrl;

  localparam int          MAXF    = 3;
  localparam int          LOCK_T  = 30;
  localparam int          OPEN_T  = 20;
  localparam logic [15:0] DEF_CODE = 16'h1234;
`ifdef DIGIT_LOCK_CODE_CHANGE_EN
  localparam bit SET_EN = 1'b1;
`else
  localparam bit SET_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic        enter_btn, lock_btn, set_btn;
  logic        unlocked, alarm;
  logic [1:0]  fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  digit_lock_ctrl #(
    .NUM_DIGITS    (4),
    .DEFAULT_CODE  (DEF_CODE),
    .MAX_FAILS     (MAXF),
    .LOCKOUT_CYCLES(LOCK_T),
    .UNLOCK_CYCLES (OPEN_T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_i (digits),
    .enter_btn(enter_btn),
    .lock_btn (lock_btn),
    .set_btn  (set_btn),
    .unlocked (unlocked),
    .alarm    (alarm),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 locked, 1 open, 2 lockout. Timed modes end at a deadline edge.
  int          edge_n = 0;
  int          mode, fails, deadline;
  logic [15:0] mcode = DEF_CODE;
  logic        prev_e, prev_l, prev_s;
  int          q_e[$], q_l[$], q_s[$];
  logic [3:0]  exp_q[$];

  function automatic bit all_bcd(input logic [15:0] d);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] nib;
      nib = (d >> (4 * i)) & 16'hF;
      if (nib > 16'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit de, dl, ds;
    edge_n++;
    if (!rst_n) begin
      mode = 0; fails = 0; deadline = 0; mcode = DEF_CODE;
      prev_e = 0; prev_l = 0; prev_s = 0;
      q_e.delete(); q_l.delete(); q_s.delete();
    end else begin
      // A press seen at this edge takes effect three edges later.
      de = 0; dl = 0; ds = 0;
      while (q_e.size() > 0 && q_e[0] == edge_n) begin de = 1; void'(q_e.pop_front()); end
      while (q_l.size() > 0 && q_l[0] == edge_n) begin dl = 1; void'(q_l.pop_front()); end
      while (q_s.size() > 0 && q_s[0] == edge_n) begin ds = 1; void'(q_s.pop_front()); end
      if (enter_btn && !prev_e) q_e.push_back(edge_n + 3);
      if (lock_btn  && !prev_l) q_l.push_back(edge_n + 3);
      if (set_btn   && !prev_s) q_s.push_back(edge_n + 3);
      prev_e = enter_btn; prev_l = lock_btn; prev_s = set_btn;

      case (mode)
        0: if (de) begin
             if (all_bcd(digits) && digits == mcode) begin
               mode = 1; fails = 0; deadline = edge_n + OPEN_T;
             end else begin
               fails++;
               if (fails == MAXF) begin mode = 2; deadline = edge_n + LOCK_T; end
             end
           end
        1: if (dl) mode = 0;
           else if (SET_EN && ds) begin
             deadline = edge_n + OPEN_T;
             if (all_bcd(digits)) begin mcode = digits; mode = 0; end
           end
           else if (OPEN_T > 0 && edge_n == deadline) mode = 0;
        default: if (edge_n == deadline) begin mode = 0; fails = 0; end
      endcase
    end
    exp_q.push_back({mode == 1, mode == 2, 2'(fails)});
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [3:0] e, g;
        e = exp_q.pop_front();
        g = {unlocked, alarm, fail_cnt};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t {unlocked,alarm,fail_cnt}: got %b/%b/%0d want %b/%b/%0d",
                   $time, g[3], g[2], g[1:0], e[3], e[2], e[1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask: bit0 enter, bit1 lock, bit2 set
  task automatic press(input logic [2:0] mask, input logic [15:0] d, input int hold);
    @(negedge clk);
    digits    = d;
    enter_btn = mask[0];
    lock_btn  = mask[1];
    set_btn   = mask[2];
    repeat (hold) @(negedge clk);
    enter_btn = 1'b0;
    lock_btn  = 1'b0;
    set_btn   = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; digits = DEF_CODE;
    enter_btn = 1'b0; lock_btn = 1'b0; set_btn = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // correct code, then auto re-lock
    press(3'b001, 16'h1234, 1);
    idle(20);

    // three failures -> lockout; enter during lockout ignored
    press(3'b001, 16'h1235, 1);
    press(3'b001, 16'h1235, 1);
    press(3'b001, 16'h1235, 1);
    press(3'b001, 16'h1234, 1);
    idle(40);

    // unlock then explicit lock
    press(3'b001, 16'h1234, 1);
    press(3'b010, 16'h1234, 1);

    // non-BCD digit, then a long enter that must count once
    press(3'b001, 16'h12A4, 1);
    press(3'b001, 16'h12A4, 10);
    press(3'b001, 16'h1234, 1);

    // lock+set together, bad set, good set, then old and new code
    press(3'b001, 16'h1234, 1);
    press(3'b110, 16'h5555, 1);
    press(3'b001, 16'h5555, 1);
    press(3'b001, 16'h1234, 1);
    press(3'b100, 16'h98A6, 1);
    press(3'b100, 16'h9876, 1);
    press(3'b001, 16'h1234, 1);
    press(3'b001, 16'h9876, 1);
    press(3'b010, 16'h0000, 1);
    idle(25);

    // async reset in the middle of lockout
    press(3'b001, 16'h0001, 1);
    press(3'b001, 16'h0001, 1);
    press(3'b001, 16'h0001, 1);
    idle(5);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({unlocked, alarm, fail_cnt} !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_reset: got unlocked=%b alarm=%b fail_cnt=%0d want 0/0/0",
               unlocked, alarm, fail_cnt);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    press(3'b001, 16'h1234, 1);
    idle(25);

    // random button levels and digits
    for (int c = 0; c < 900; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 12)      enter_btn = ~enter_btn;
      else if (r < 18) lock_btn  = ~lock_btn;
      else if (r < 23) set_btn   = ~set_btn;
      if ($urandom_range(0, 3) == 0)
        digits = ($urandom_range(0, 1) == 1) ? mcode : 16'($urandom);
    end
    enter_btn = 1'b0; lock_btn = 1'b0; set_btn = 1'b0;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
